key_debounce_repeat: RTL

- Parametrised N-channel front end for the game push-buttons (start, esc, up, down, left, right, and any added later).
- Each channel is synchronised and debounced, then produces a level output plus one-cycle press/release strobes.
- Optional per-channel auto-repeat is provided for held direction keys.
- Sits between the board pins and the snake game controller; replaces ad-hoc per-key edge detection.

---
 rtl/key_if.sv | 27 ++
 rtl/key_debounce_repeat.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/key_if.sv
// Key front-end bundle: raw pins and repeat enables in,
// debounced level, press/release/repeat strobes, any_event, last_key out.
interface key_if #(
  parameter int N_KEYS = 6,
  parameter int IDX_W  = 3
);
  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] repeat_en;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_repeat;
  logic              any_event;
  logic [IDX_W-1:0]  last_key;

  modport master (
    output key_in, repeat_en,
    input  key_level, key_press, key_release,
    input  key_repeat, any_event, last_key
  );

  modport slave (
    input  key_in, repeat_en,
    output key_level, key_press, key_release,
    output key_repeat, any_event, last_key
  );
endinterface

// File: rtl/key_debounce_repeat.sv
// N-channel key sync + debounce + auto-repeat front end.
// Ports: clk, rst_n (async low), kif (key_if.slave: pins in, events out).
module key_debounce_repeat #(
  parameter int N_KEYS       = 6,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input logic  clk,
  input logic  rst_n,
  key_if.slave kif
);
  localparam int M1 =
    DEBOUNCE_CYC > REPEAT_DELAY ? DEBOUNCE_CYC : REPEAT_DELAY;
  localparam int MX = M1 > REPEAT_RATE ? M1 : REPEAT_RATE;
  localparam int CNT_W = $clog2(MX + 1);
  localparam int IDX_W = N_KEYS > 1 ? $clog2(N_KEYS) : 1;

  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);
  localparam logic [N_KEYS-1:0] PIN_IDLE = {N_KEYS{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    RPT
  } rpt_st_e;

  logic [N_KEYS-1:0] sync1, sync2, s;
  logic [N_KEYS-1:0] lvl_q, lvl_d;
  logic [N_KEYS-1:0] prs_q, prs_d;
  logic [N_KEYS-1:0] rel_q, rel_d;
  logic [N_KEYS-1:0] rep_q, rep_d;
  logic              any_q, any_d;
  logic [IDX_W-1:0]  lk_q, lk_d;
  logic [CNT_W-1:0]  dcnt_q [N_KEYS];
  logic [CNT_W-1:0]  dcnt_d [N_KEYS];
  logic [CNT_W-1:0]  rcnt_q [N_KEYS];
  logic [CNT_W-1:0]  rcnt_d [N_KEYS];
  rpt_st_e           st_q   [N_KEYS];
  rpt_st_e           st_d   [N_KEYS];

  assign s = sync2 ^ PIN_IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= PIN_IDLE;
      sync2 <= PIN_IDLE;
      lvl_q <= '0;
      prs_q <= '0;
      rel_q <= '0;
      rep_q <= '0;
      any_q <= 1'b0;
      lk_q  <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        dcnt_q[i] <= '0;
        rcnt_q[i] <= '0;
        st_q[i]   <= IDLE;
      end
    end else begin
      sync1 <= kif.key_in;
      sync2 <= sync1;
      lvl_q <= lvl_d;
      prs_q <= prs_d;
      rel_q <= rel_d;
      rep_q <= rep_d;
      any_q <= any_d;
      lk_q  <= lk_d;
      for (int i = 0; i < N_KEYS; i++) begin
        dcnt_q[i] <= dcnt_d[i];
        rcnt_q[i] <= rcnt_d[i];
        st_q[i]   <= st_d[i];
      end
    end
  end

  always_comb begin
    lvl_d  = lvl_q;
    prs_d  = '0;
    rel_d  = '0;
    rep_d  = '0;
    dcnt_d = dcnt_q;
    rcnt_d = rcnt_q;
    st_d   = st_q;
    for (int i = 0; i < N_KEYS; i++) begin
      if (s[i] == lvl_q[i]) begin
        dcnt_d[i] = '0;
      end else if (dcnt_q[i] == D_LAST) begin
        dcnt_d[i] = '0;
        lvl_d[i]  = s[i];
        prs_d[i]  = s[i];
        rel_d[i]  = ~s[i];
      end else begin
        dcnt_d[i] = dcnt_q[i] + 1'b1;
      end

      // The FSM reacts to the press/release decided this edge so
      // the first repeat lands exactly REPEAT_DELAY after the press.
      unique case (st_q[i])
        IDLE: begin
          if (prs_d[i]) begin
            st_d[i]   = HELD;
            rcnt_d[i] = '0;
          end
        end
        HELD: begin
          if (rel_d[i]) begin
            st_d[i]   = IDLE;
            rcnt_d[i] = '0;
          end else if (rcnt_q[i] == RD_LAST) begin
            if (kif.repeat_en[i]) begin
              rep_d[i]  = 1'b1;
              rcnt_d[i] = '0;
              st_d[i]   = RPT;
            end
          end else begin
            rcnt_d[i] = rcnt_q[i] + 1'b1;
          end
        end
        RPT: begin
          if (rel_d[i]) begin
            st_d[i]   = IDLE;
            rcnt_d[i] = '0;
          end else if (!kif.repeat_en[i]) begin
            st_d[i]   = HELD;
            rcnt_d[i] = RD_LAST;
          end else if (rcnt_q[i] == RR_LAST) begin
            rep_d[i]  = 1'b1;
            rcnt_d[i] = '0;
          end else begin
            rcnt_d[i] = rcnt_q[i] + 1'b1;
          end
        end
        default: begin
          st_d[i]   = IDLE;
          rcnt_d[i] = '0;
        end
      endcase
    end

    any_d = |(prs_d | rep_d);
    lk_d  = lk_q;
    // Descending scan: lowest active index wins.
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (prs_d[i] | rep_d[i]) lk_d = IDX_W'(i);
    end
  end

  assign kif.key_level   = lvl_q;
  assign kif.key_press   = prs_q;
  assign kif.key_release = rel_q;
  assign kif.key_repeat  = rep_q;
  assign kif.any_event   = any_q;
  assign kif.last_key    = lk_q;
endmodule
